oam_dma_engine: RTL and testbench

Parametrised sprite-DMA engine for the NES CPU bus. It replaces the free-running `$4014` page-copy counter with a proper state machine. A CPU write to the trigger address latches a source page and stalls the CPU. The engine then alternates read and write cycles to copy `LEN` bytes from CPU address space into the PPU OAM port, with optional odd-cycle alignment, abort, and a completion pulse. It sits between the CPU bus decode and the PPU OAM write port, and its `cpu_stall` output gates the CPU enable.

---
 rtl/oam_dma_engine.sv | 139 +++++++++++++
 tb/tb_oam_dma_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_engine.sv
// ---------------------------------------------------------------------------
// oam_dma_engine
// Sprite DMA engine for the NES CPU bus. A CPU write to TRIGGER_ADDR latches
// a source page and stalls the CPU. The engine then alternates READ and WRITE
// cycles to copy LEN bytes from (page << PAGE_SHIFT) into the PPU OAM port.
// An optional ALIGN cycle makes every READ land on an even (p==0) cycle.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   ENABLE            global enable; low freezes all state and kills strobes
//   cpu_addr/wdata/we CPU bus write snoop (trigger detection)
//   abort             cancel an active transfer (ignored when IDLE)
//   bus_rdata         source read data, valid the cycle after bus_rden
//   cpu_stall, busy   high in every non-IDLE state
//   bus_addr/bus_rden DMA source read
//   dst_addr/data/wren OAM write port
//   done              one-cycle pulse after the last WRITE
// ---------------------------------------------------------------------------
module oam_dma_engine #(
    parameter int          ADDR_W       = 16,
    parameter int          DATA_W       = 8,
    parameter int          LEN          = 256,
    parameter int          PAGE_SHIFT   = 8,
    parameter int unsigned TRIGGER_ADDR = 32'h4014,
    parameter bit          ALIGN_EN     = 1'b1,
    localparam int         IDX_W        = $clog2(LEN)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              abort,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rden,
    output logic [IDX_W-1:0]  dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wren,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              p_q, p_d;
    logic              done_q, done_d;

    logic              trigger;
    logic              last;
    logic [ADDR_W-1:0] base;

    assign trigger = cpu_we && (cpu_addr == ADDR_W'(TRIGGER_ADDR));
    assign last    = (idx_q == IDX_W'(LEN - 1));
    // Source base wraps modulo 2^ADDR_W; the idx add wraps the same way.
    assign base    = ADDR_W'(page_q) << PAGE_SHIFT;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            p_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        p_d     = p_q;
        done_d  = done_q;
        if (ENABLE) begin
            p_d    = ~p_q;
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        page_d  = cpu_wdata;
                        idx_d   = '0;
                        state_d = HALT;
                    end
                end
                // HALT at p==1 means the next cycle is even, so READ directly.
                HALT:  state_d = (!ALIGN_EN || p_q) ? READ : ALIGN;
                ALIGN: state_d = READ;
                READ:  state_d = WRITE;
                WRITE: begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Abort wins over completion: no done pulse on an aborted last WRITE.
            if (abort && (state_q != IDLE)) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b0;
            end
        end
    end

    // Outputs decode the current state, so a strobe already up in the abort
    // cycle still completes; the next cycle is IDLE and strobe-free.
    always_comb begin
        busy      = (state_q != IDLE);
        cpu_stall = busy;
        bus_rden  = ENABLE && (state_q == READ);
        bus_addr  = (state_q == READ) ? (base + ADDR_W'(idx_q)) : '0;
        dst_wren  = ENABLE && (state_q == WRITE);
        dst_addr  = (state_q == WRITE) ? idx_q : '0;
        dst_data  = (state_q == WRITE) ? bus_rdata : '0;
        done      = done_q && ENABLE;
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_engine
// Two engines: u_a with defaults (LEN=256, PAGE_SHIFT=8, ALIGN_EN=1) and
// u_b with LEN=4, PAGE_SHIFT=2, ALIGN_EN=0. Stimulus pushes the reads,
// writes, stall length and done tokens a transfer should produce; per-DUT
// monitors on the falling edge pop and compare whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_oam_dma_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        ENABLE = 1'b1;
    logic [15:0] cpu_addr = 16'h4014;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  bus_rdata = '0;
    logic        cpu_stall, busy, bus_rden, dst_wren, done;
    logic [15:0] bus_addr;
    logic [7:0]  dst_addr, dst_data;

    logic        en_b = 1'b1;
    logic        abort_b = 1'b0;
    logic [15:0] cpu_addr_b = 16'h4014;
    logic [7:0]  cpu_wdata_b = '0;
    logic        cpu_we_b = 1'b0;
    logic [7:0]  bus_rdata_b = '0;
    logic        cpu_stall_b, busy_b, bus_rden_b, dst_wren_b, done_b;
    logic [15:0] bus_addr_b;
    logic [1:0]  dst_addr_b;
    logic [7:0]  dst_data_b;

    oam_dma_engine u_a (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .abort(abort),
        .bus_rdata(bus_rdata), .cpu_stall(cpu_stall), .busy(busy),
        .bus_addr(bus_addr), .bus_rden(bus_rden), .dst_addr(dst_addr),
        .dst_data(dst_data), .dst_wren(dst_wren), .done(done)
    );

    oam_dma_engine #(.LEN(4), .PAGE_SHIFT(2), .ALIGN_EN(1'b0)) u_b (
        .CLK(CLK), .RESET(RESET), .ENABLE(en_b), .cpu_addr(cpu_addr_b),
        .cpu_wdata(cpu_wdata_b), .cpu_we(cpu_we_b), .abort(abort_b),
        .bus_rdata(bus_rdata_b), .cpu_stall(cpu_stall_b), .busy(busy_b),
        .bus_addr(bus_addr_b), .bus_rden(bus_rden_b), .dst_addr(dst_addr_b),
        .dst_data(dst_data_b), .dst_wren(dst_wren_b), .done(done_b)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    endtask

    // Source memory contents as a pure function of address.
    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    // Source bus: data returned the cycle after the read strobe.
    always @(posedge CLK) begin
        if (bus_rden)   bus_rdata   <= mem(bus_addr);
        if (bus_rden_b) bus_rdata_b <= mem(bus_addr_b);
    end

    // Cycle parity: 0 in the first enabled cycle after reset, toggles when enabled.
    logic tb_p;
    always @(posedge CLK or posedge RESET) begin
        if (RESET)       tb_p <= 1'b0;
        else if (ENABLE) tb_p <= ~tb_p;
    end

    logic [15:0] rd_a[$], wr_a[$], rd_b[$], wr_b[$];
    int          st_a[$], st_b[$];
    bit          dn_a[$], dn_b[$];
    int          last_a;

    // Reference model: n bytes from (page << shift), stall = 1 + a + 2n + extra.
    task automatic push(input bit isb, input logic [7:0] pg, input int n,
                        input int a, input int extra, input bit dn);
        logic [15:0] base, ad;
        base = isb ? (16'(pg) << 2) : (16'(pg) << 8);
        for (int i = 0; i < n; i++) begin
            ad = base + 16'(i);
            if (isb) begin rd_b.push_back(ad); wr_b.push_back({8'(i), mem(ad)}); end
            else     begin rd_a.push_back(ad); wr_a.push_back({8'(i), mem(ad)}); end
        end
        if (isb) begin st_b.push_back(1 + a + 2*n + extra); if (dn) dn_b.push_back(1'b1); end
        else     begin st_a.push_back(1 + a + 2*n + extra); if (dn) dn_a.push_back(1'b1); end
    endtask

    // Trigger (optionally waiting for a parity; want_p<0 means now).
    // Returns at #1 into the HALT cycle.
    task automatic trig(input bit isb, input logic [7:0] pg, input int want_p,
                        input int n, input int extra, input bit dn);
        int a;
        int guard;
        guard = 0;
        while (want_p >= 0 && tb_p != want_p[0] && guard < 4) begin
            @(posedge CLK); #1; guard++;
        end
        a = (!isb && tb_p == 1'b1) ? 1 : 0;
        last_a = a;
        push(isb, pg, n, a, extra, dn);
        if (isb) begin cpu_we_b = 1'b1; cpu_wdata_b = pg; end
        else     begin cpu_we   = 1'b1; cpu_wdata   = pg; end
        @(posedge CLK); #1;
        cpu_we = 1'b0; cpu_we_b = 1'b0;
    endtask

    task automatic wait_idle(input bit isb, input int max);
        int k;
        k = 0;
        do begin @(posedge CLK); #1; k++; end
        while ((isb ? busy_b : busy) && k < max);
        chk(isb ? "idle_timeout_b" : "idle_timeout_a", isb ? busy_b : busy, 0);
    endtask

    // Monitor A.
    int cnt_a = 0;
    bit done_prev_a = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            cnt_a = 0; done_prev_a = 0;
        end else begin
            if (!ENABLE) begin
                chk("freeze_strobe", {bus_rden, dst_wren, done}, 0);
                chk("freeze_stall", cpu_stall, 1);
            end
            if (bus_rden) begin
                chk("rd_underflow", rd_a.size() > 0, 1);
                if (rd_a.size() > 0) chk("rd_addr", bus_addr, rd_a.pop_front());
                chk("rd_parity", tb_p, 0);
            end
            if (dst_wren) begin
                chk("wr_underflow", wr_a.size() > 0, 1);
                if (wr_a.size() > 0) chk("wr_idx_data", {dst_addr, dst_data}, wr_a.pop_front());
            end
            if (done) begin
                chk("done_underflow", dn_a.size() > 0, 1);
                if (dn_a.size() > 0) void'(dn_a.pop_front());
                chk("done_stall_low", cpu_stall, 0);
                chk("done_single", done_prev_a, 0);
            end
            done_prev_a = done;
            if (cpu_stall) cnt_a++;
            else if (cnt_a > 0) begin
                chk("stall_underflow", st_a.size() > 0, 1);
                if (st_a.size() > 0) chk("stall_len", cnt_a, st_a.pop_front());
                cnt_a = 0;
            end
        end
    end

    // Monitor B.
    int cnt_b = 0;
    always @(negedge CLK) begin
        if (RESET) cnt_b = 0;
        else begin
            if (bus_rden_b) begin
                chk("rd_underflow_b", rd_b.size() > 0, 1);
                if (rd_b.size() > 0) chk("rd_addr_b", bus_addr_b, rd_b.pop_front());
            end
            if (dst_wren_b) begin
                chk("wr_underflow_b", wr_b.size() > 0, 1);
                if (wr_b.size() > 0) chk("wr_idx_data_b", {6'd0, dst_addr_b, dst_data_b}, wr_b.pop_front());
            end
            if (done_b) begin
                chk("done_underflow_b", dn_b.size() > 0, 1);
                if (dn_b.size() > 0) void'(dn_b.pop_front());
                chk("done_stall_low_b", cpu_stall_b, 0);
            end
            if (cpu_stall_b) cnt_b++;
            else if (cnt_b > 0) begin
                chk("stall_underflow_b", st_b.size() > 0, 1);
                if (st_b.size() > 0) chk("stall_len_b", cnt_b, st_b.pop_front());
                cnt_b = 0;
            end
        end
    end

    initial begin
        logic [7:0] pg;
        #1 RESET = 1'b1;
        #2;
        chk("reset_out_a", {cpu_stall, busy, bus_addr, bus_rden, dst_addr, dst_data, dst_wren, done}, 0);
        chk("reset_out_b", {cpu_stall_b, busy_b, bus_addr_b, bus_rden_b, dst_addr_b, dst_data_b, dst_wren_b, done_b}, 0);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // Write to a neighbouring address must not start anything.
        cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_wdata = 8'h02;
        @(posedge CLK); #1; cpu_we = 1'b0; cpu_addr = 16'h4014;
        chk("non_trigger_idle", busy, 0);

        // Basic copy of page $02 from an even cycle: 513-cycle stall.
        trig(0, 8'h02, 0, 256, 0, 1);
        chk("halt_stall", cpu_stall, 1);
        wait_idle(0, 600);
        // Back-to-back trigger in the done cycle.
        pg = 8'($urandom_range(0, 255));
        trig(0, pg, -1, 256, 0, 1);
        wait_idle(0, 600);
        // Odd-parity trigger: ALIGN inserted, 514-cycle stall.
        trig(0, 8'h10, 1, 256, 0, 1);
        wait_idle(0, 600);

        // Abort in the 10th WRITE: 10 writes, no done.
        pg = 8'($urandom_range(0, 255));
        trig(0, pg, int'($urandom_range(0, 1)), 10, 0, 0);
        repeat (last_a + 20) @(posedge CLK);
        #1 abort = 1'b1;
        chk("abort_in_write", dst_wren, 1);
        @(posedge CLK); #1 abort = 1'b0;
        chk("abort_idle", {busy, cpu_stall, bus_rden, dst_wren, done}, 0);
        trig(0, 8'h21, -1, 256, 0, 1);
        wait_idle(0, 600);

        // Freeze for 5 cycles in the 7th READ, then a trigger write while busy.
        trig(0, 8'h44, -1, 256, 5, 1);
        repeat (last_a + 13) @(posedge CLK);
        #1 ENABLE = 1'b0;
        repeat (5) @(posedge CLK);
        #1 ENABLE = 1'b1;
        repeat (20) @(posedge CLK);
        #1 cpu_we = 1'b1; cpu_wdata = 8'h99;
        @(posedge CLK); #1 cpu_we = 1'b0;
        wait_idle(0, 600);

        // Page $FF with shift 8: $FF00-$FFFF.
        trig(0, 8'hFF, -1, 256, 0, 1);
        wait_idle(0, 600);

        // Reset in the 100th READ.
        trig(0, 8'h03, -1, 256, 0, 1);
        repeat (last_a + 199) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("midreset_out", {cpu_stall, busy, bus_addr, bus_rden, dst_addr, dst_data, dst_wren, done}, 0);
        rd_a.delete(); wr_a.delete(); st_a.delete(); dn_a.delete();
        @(posedge CLK); #1 RESET = 1'b0;
        // First cycle after release has p==0: no ALIGN, 513-cycle stall.
        trig(0, 8'h05, -1, 256, 0, 1);
        wait_idle(0, 600);

        // Small engine: page $FF, shift 2 -> $03FC-$03FF, 9-cycle stall either parity.
        trig(1, 8'hFF, 0, 4, 0, 1);
        wait_idle(1, 20);
        trig(1, 8'hFF, 1, 4, 0, 1);
        wait_idle(1, 20);
        pg = 8'($urandom_range(0, 255));
        trig(1, pg, -1, 4, 0, 1);
        wait_idle(1, 20);

        repeat (4) @(posedge CLK);
        #1;
        chk("left_a", rd_a.size() + wr_a.size() + st_a.size() + dn_a.size(), 0);
        chk("left_b", rd_b.size() + wr_b.size() + st_b.size() + dn_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
